// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, splits the fetched word into decoder fields,
// computes the next PC from branch/jump/zero, and runs an IDLE/RUN/HALT sequencer.
//
// state  | meaning
// IDLE   | after reset; PC held, no fetch issued to the decoder, waits for start
// RUN    | one instruction fetched and retired per cycle
// HALT   | stopped on a halt opcode or fetch fault; PC frozen, waits for start
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_WORDS  = 64,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    localparam int         AW          = $clog2(IMEM_WORDS)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          start,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_data,
    input  logic          branch,
    input  logic          jump,
    input  logic          zero,
    output logic [31:0]   pc,
    output logic [31:0]   pc_plus4,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [5:0]    opcode,
    output logic [5:0]    funct,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [4:0]    shamt,
    output logic [15:0]   imm16,
    output logic          halted,
    output logic          fault,
    output logic [31:0]   retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] retired_q;
    logic        fault_q;
    logic        halted_q;
    logic        valid_q;

    logic [31:0] pc_d;
    logic [31:0] retired_d;
    logic [31:0] br_off;
    logic        range_ok;

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q[AW+1:2];

    // valid_q mirrors state_q == S_RUN, so the word is gated outside RUN
    assign instr  = valid_q ? imem_data : 32'h0;
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign retired     = retired_q;

    assign range_ok  = (pc_q[31:AW+2] == '0) && (pc_q[1:0] == 2'b00);
    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign retired_d = (retired_q == 32'hFFFF_FFFF) ? retired_q : retired_q + 32'd1;

    always_comb begin
        pc_d = pc_plus4;
        if (jump) begin
            pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            pc_d = pc_plus4 + br_off;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            retired_q <= 32'h0;
            fault_q   <= 1'b0;
            halted_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        pc_q      <= RESET_PC;
                        retired_q <= 32'h0;
                        fault_q   <= 1'b0;
                        halted_q  <= 1'b0;
                        valid_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A bad fetch address outranks whatever the memory returned
                    if (!range_ok) begin
                        state_q  <= S_HALT;
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        valid_q  <= 1'b0;
                    end else if (opcode == HALT_OPCODE) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        valid_q  <= 1'b0;
                    end else begin
                        pc_q      <= pc_d;
                        retired_q <= retired_d;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    halted_q <= 1'b0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed programs in a behavioural IMEM, expected
// (pc, retired) pairs queued per run and checked by a monitor on every valid fetch.
module tb_instr_fetch_unit;

    localparam int AW = 6;

    logic          CLK;
    logic          RST_n;
    logic          start;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          branch, jump, zero;
    logic [31:0]   pc, pc_plus4, instr, retired;
    logic          instr_valid, halted, fault;
    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   imm16;

    logic [31:0] mem [0:63];
    logic        br_force, j_force, zero_tb;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] mon_i;
    int          n_vec = 0;
    int          n_err = 0;

    instr_fetch_unit #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (64),
        .HALT_OPCODE(6'b111111)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr      (instr),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .funct      (funct),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .imm16      (imm16),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Minimal control decoder: beq is opcode 4, j is opcode 2
    assign imem_data = mem[imem_addr];
    assign branch    = (instr[31:26] == 6'd4) | br_force;
    assign jump      = (instr[31:26] == 6'd2) | j_force;
    assign zero      = zero_tb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_n === 1'b1 && instr_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_fetch: got pc %h expected no fetch", pc);
            end else begin
                mon_e = q.pop_front();
                mon_i = mem[mon_e.pc[7:2]];
                chk("pc", pc, mon_e.pc);
                chk("retired", retired, mon_e.ret);
                chk("instr", instr, mon_i);
                chk("fields", {opcode, rs, rt, rd, shamt, funct}, mon_i);
                chk("imm16", {16'h0, imm16}, {16'h0, mon_i[15:0]});
                chk("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
            end
        end
    end

    task automatic push(input logic [31:0] p, input logic [31:0] r);
        exp_t e;
        e.pc  = p;
        e.ret = r;
        q.push_back(e);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 64; i++) mem[i] = 32'hFC00_0000;
    endtask

    task automatic do_run(input logic [31:0] epc, input logic [31:0] eret, input logic efault);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("run_valid", 32'(instr_valid), 32'd1);
        chk("run_fault_clear", 32'(fault), 32'd0);
        chk("run_not_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 100 && halted !== 1'b1; i++) @(negedge CLK);
        chk("halt_reached", 32'(halted), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_pc", pc, epc);
        chk("final_retired", retired, eret);
        chk("final_fault", 32'(fault), 32'(efault));
        chk("halt_instr_zero", instr, 32'h0);
        chk("halt_valid_low", 32'(instr_valid), 32'd0);
        repeat (2) @(negedge CLK);
        chk("halt_pc_frozen", pc, epc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n    = 1'b0;
        start    = 1'b0;
        br_force = 1'b0;
        j_force  = 1'b0;
        zero_tb  = 1'b0;
        fill_halt();
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        @(negedge CLK);
        #1 RST_n = 1'b1;

        // addi, addi, add, halt
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_0003;
        mem[2] = 32'h0022_1820;
        mem[3] = 32'hFC00_0000;
        push(32'h0, 0); push(32'h4, 1); push(32'h8, 2); push(32'hC, 3);
        do_run(32'hC, 32'd3, 1'b0);

        // j 0x10; beq at 0x10 with imm -4 -> 0x04 (halt)
        fill_halt();
        mem[0] = 32'h0800_0004;
        mem[4] = 32'h1000_FFFC;
        zero_tb = 1'b1;
        push(32'h0, 0); push(32'h10, 1); push(32'h4, 2);
        do_run(32'h4, 32'd2, 1'b0);

        // same beq, not taken -> 0x14 (halt)
        zero_tb = 1'b0;
        push(32'h0, 0); push(32'h10, 1); push(32'h14, 2);
        do_run(32'h14, 32'd2, 1'b0);

        // j 0x20; j 0x40 (halt)
        fill_halt();
        mem[0] = 32'h0800_0008;
        mem[8] = 32'h0800_0010;
        push(32'h0, 0); push(32'h20, 1); push(32'h40, 2);
        do_run(32'h40, 32'd2, 1'b0);

        // jump beats a simultaneous taken branch
        br_force = 1'b1;
        zero_tb  = 1'b1;
        push(32'h0, 0); push(32'h20, 1); push(32'h40, 2);
        do_run(32'h40, 32'd2, 1'b0);
        br_force = 1'b0;
        zero_tb  = 1'b0;

        // j 0x100 lands outside a 64-word IMEM -> fault; restart clears it
        fill_halt();
        mem[0] = 32'h0800_0040;
        push(32'h0, 0); push(32'h100, 1);
        do_run(32'h100, 32'd1, 1'b1);
        push(32'h0, 0); push(32'h100, 1);
        do_run(32'h100, 32'd1, 1'b1);

        // reset between edges while RUN at pc 0x0C
        fill_halt();
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        push(32'h0, 0); push(32'h4, 1); push(32'h8, 2); push(32'hC, 3);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        RST_n = 1'b0;
        start = 1'b1;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_retired", retired, 32'h0);
        chk("midrst_queue", 32'(q.size()), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_held_pc", pc, 32'h0);
        chk("rst_held_valid", 32'(instr_valid), 32'd0);
        start = 1'b0;
        #1 RST_n = 1'b1;

        // IDLE ignores control inputs
        for (int i = 0; i < 8; i++) begin
            br_force = i[0];
            j_force  = i[1];
            zero_tb  = i[2];
            @(negedge CLK);
            chk("idle_pc", pc, 32'h0);
            chk("idle_instr", instr, 32'h0);
            chk("idle_retired", retired, 32'h0);
            chk("idle_valid", 32'(instr_valid), 32'd0);
        end
        br_force = 1'b0;
        j_force  = 1'b0;
        zero_tb  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
